mdu_unit: RTL

- Multiply/divide unit in the E stage of the five-stage MIPS pipeline, owning the HI/LO registers.
- It is the responder side of the hazard unit's mult/div interlock: it consumes Start/HIWrite/LOWrite/HIRead/LORead and produces Busy, which the hazard unit uses to stall D.
- It models fixed-latency mult/div, services mthi/mtlo/mfhi/mflo, and cancels any operation flagged by an exception request.

---
 rtl/mdu_pkg.sv | 80 ++++++++
 rtl/mdu_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit and the control decoder:
//   - MDOp encodings for mult/multu/div/divu
//   - default mult/div latencies (Busy cycles)
//   - counter width used by the MDU latency counter
//   - md_compute(): 64-bit {HI,LO} result of one MDU operation
// -----------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  // Returns {hi, lo}. Divide-by-zero yields a don't-care value; the caller
  // suppresses the commit in that case, so the divisor is forced to 1 only to
  // keep the divider well defined.
  function automatic logic [63:0] md_compute(input md_op_e op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] res;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    res   = 64'd0;
    mag_a = 32'd0;
    mag_b = 32'd1;
    quo   = 32'd0;
    rem   = 32'd0;
    quo_s = 32'd0;
    rem_s = 32'd0;
    case (op)
      // Sign-extended operands multiplied modulo 2^64 give the signed product.
      MD_MULT: begin
        res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      end
      MD_MULTU: begin
        res = {32'd0, a} * {32'd0, b};
      end
      // Signed divide on magnitudes; quotient negated when signs differ,
      // remainder takes the dividend's sign. 0x80000000/-1 falls out as
      // 0x80000000 rem 0 without special casing.
      MD_DIV: begin
        mag_a = a[31] ? (32'd0 - a) : a;
        mag_b = b[31] ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
          mag_b = 32'd1;
        end else begin
          mag_b = mag_b;
        end
        quo   = mag_a / mag_b;
        rem   = mag_a % mag_b;
        quo_s = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
        rem_s = a[31] ? (32'd0 - rem) : rem;
        res   = {rem_s, quo_s};
      end
      MD_DIVU: begin
        mag_b = (b == 32'd0) ? 32'd1 : b;
        quo   = a / mag_b;
        rem   = a % mag_b;
        res   = {rem, quo};
      end
      default: begin
        res = 64'd0;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit
// E-stage multiply/divide unit owning the HI/LO registers. Models fixed-latency
// mult/div: the result is computed when the operation is accepted and held
// until the latency counter expires, then committed to HI/LO.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   Start, MDOp       start mult/multu/div/divu (MDOp encoding in mdu_pkg)
//   HIWrite, LOWrite  mthi / mtlo (HI/LO <= A)
//   HIRead, LORead    mfhi / mflo select for MDOut
//   Req               exception taken; cancels this cycle's Start/HIWrite/LOWrite
//   A, B              forwarded rs / rt operands
//   Busy              operation in flight (not asserted in the Start cycle)
//   HI, LO            architectural HI/LO
//   MDOut             HIRead ? HI : LORead ? LO : 0 (combinational)
// -----------------------------------------------------------------------------
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        HIRead,
  input  logic        LORead,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             busy_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      hi_next_s;
  logic [31:0]      lo_next_s;
  logic [31:0]      temp_hi_r;
  logic [31:0]      temp_lo_r;
  logic [31:0]      temp_hi_next_s;
  logic [31:0]      temp_lo_next_s;
  logic             commit_ok_r;
  logic             commit_ok_next_s;
  logic [63:0]      result_s;
  logic             is_div_s;

  assign result_s = md_compute(md_op_e'(MDOp), A, B);
  assign is_div_s = MDOp[1];

  // Next-state: start/latch an operation, count down, commit, or service mthi/mtlo.
  always_comb begin
    cnt_next_s       = cnt_r;
    hi_next_s        = hi_r;
    lo_next_s        = lo_r;
    temp_hi_next_s   = temp_hi_r;
    temp_lo_next_s   = temp_lo_r;
    commit_ok_next_s = commit_ok_r;
    if (cnt_r != {CNT_W{1'b0}}) begin
      // Running: new Start/HIWrite/LOWrite are ignored while busy.
      cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
        commit_ok_next_s = 1'b0;
        if (commit_ok_r) begin
          hi_next_s = temp_hi_r;
          lo_next_s = temp_lo_r;
        end else begin
          // Divide by zero: HI/LO keep their prior values.
          hi_next_s = hi_r;
          lo_next_s = lo_r;
        end
      end else begin
        commit_ok_next_s = commit_ok_r;
      end
    end else if (!Req) begin
      if (Start) begin
        temp_hi_next_s   = result_s[63:32];
        temp_lo_next_s   = result_s[31:0];
        commit_ok_next_s = !(is_div_s && (B == 32'd0));
        cnt_next_s       = is_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (HIWrite) begin
        hi_next_s = A;
      end else if (LOWrite) begin
        lo_next_s = A;
      end else begin
        cnt_next_s = cnt_r;
      end
    end else begin
      // Exception taken: the E-stage MDU instruction is cancelled.
      cnt_next_s = cnt_r;
    end
  end

  // State registers: counter, Busy, pending result and HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      temp_hi_r   <= 32'd0;
      temp_lo_r   <= 32'd0;
      commit_ok_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_next_s;
      busy_r      <= (cnt_next_s != {CNT_W{1'b0}});
      hi_r        <= hi_next_s;
      lo_r        <= lo_next_s;
      temp_hi_r   <= temp_hi_next_s;
      temp_lo_r   <= temp_lo_next_s;
      commit_ok_r <= commit_ok_next_s;
    end
  end

  assign Busy  = busy_r;
  assign HI    = hi_r;
  assign LO    = lo_r;
  assign MDOut = HIRead ? hi_r : (LORead ? lo_r : 32'd0);

endmodule
